// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every handshake and data signal of the shared memory port arbiter:
// the I-cache refill client, the D-cache refill/writeback client and the
// external memory command/data port.
//
// Modports:
//   master - the arbiter. Drives grants, returned data and completions to
//            both caches, plus the memory command and write-data phase.
//   slave  - the environment (caches + memory). Drives requests, write data
//            and the memory ready/read-data responses.
//
// Parameters: ADDR_W (byte address width), DATA_W (beat width).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // I-cache client
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_gnt;
  logic              ic_rvalid;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_done;

  // D-cache client
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_wready;
  logic              dc_gnt;
  logic              dc_rvalid;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_done;

  // External memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wvalid;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ic_req, ic_addr,
    output ic_gnt, ic_rvalid, ic_rdata, ic_done,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    output dc_wready, dc_gnt, dc_rvalid, dc_rdata, dc_done,
    output mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    output ic_req, ic_addr,
    input  ic_gnt, ic_rvalid, ic_rdata, ic_done,
    output dc_req, dc_we, dc_addr, dc_wdata,
    input  dc_wready, dc_gnt, dc_rvalid, dc_rdata, dc_done,
    input  mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single external memory port between the I-cache refill engine
// and the D-cache refill/writeback engine. One line-sized burst is in flight
// at a time; the block sequences command, write-data and read-data phases and
// routes returned data and the completion pulse back to the owning cache.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset (abandons any transaction)
//   bus  - mem_port_arbiter_if.master: I-cache, D-cache and memory signals
//
// Parameters:
//   ADDR_W, DATA_W - address / beat widths
//   BURST_LEN      - beats per line transaction (>= 1)
//   MAX_STREAK     - consecutive D grants allowed while I waits (>= 1)
//
// Build option:
//   MEM_ARB_FAIRNESS_EN - when defined, a streak counter lets the I-cache win
//   after MAX_STREAK back-to-back D grants made while I was waiting. When
//   undefined, D always beats I and no streak counter is built.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 4,
  parameter int MAX_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("mem_port_arbiter: BURST_LEN must be >= 1");
  end
  if (MAX_STREAK < 1) begin : g_bad_max_streak
    $error("mem_port_arbiter: MAX_STREAK must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // The counter must be able to hold BURST_LEN itself after the final beat.
  localparam int                CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [CNT_W-1:0]  beat_q;
  logic              first_cmd_q;   // gnt is a pulse on the first CMD cycle only

  logic              grant_i;
  logic              grant_d;
  logic              i_starved;
  logic              beat_evt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  logic [STREAK_W-1:0] streak_q;

  // Only D grants that overtook a waiting I count toward the streak; the
  // streak can never pass MAX_STREAK because at that value I wins the tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (grant_i) begin
      streak_q <= '0;
    end else if (grant_d) begin
      streak_q <= bus.ic_req ? streak_q + STREAK_W'(1) : '0;
    end
  end

  assign i_starved = (streak_q == STREAK_W'(MAX_STREAK));
`else
  assign i_starved = 1'b0;
`endif

  assign grant_d = (state_q == S_IDLE) && bus.dc_req && !(bus.ic_req && i_starved);
  assign grant_i = (state_q == S_IDLE) && bus.ic_req && !grant_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    beat_evt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_d || grant_i) state_d = S_CMD;
      end
      S_CMD: begin
        if (bus.mem_ready) state_d = we_q ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        beat_evt = bus.mem_ready;
        if (beat_evt && (beat_q == LAST_BEAT)) state_d = S_DONE;
      end
      S_READ: begin
        beat_evt = bus.mem_rvalid;
        if (beat_evt && (beat_q == LAST_BEAT)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and transaction registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      addr_q      <= '0;
      we_q        <= 1'b0;
      beat_q      <= '0;
      first_cmd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_cmd_q <= grant_d || grant_i;

      if (grant_d) begin
        owner_q <= OWN_D;
        addr_q  <= bus.dc_addr;
        we_q    <= bus.dc_we;
      end else if (grant_i) begin
        owner_q <= OWN_I;
        addr_q  <= bus.ic_addr;
        we_q    <= 1'b0;          // the I-cache only ever refills
      end

      if (state_q == S_CMD) begin
        beat_q <= '0;
      end else if (beat_evt) begin
        beat_q <= beat_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state and owner so reset clears them immediately,
  // and the non-owner never sees data or completion.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.ic_gnt     = 1'b0;
    bus.ic_rvalid  = 1'b0;
    bus.ic_rdata   = '0;
    bus.ic_done    = 1'b0;
    bus.dc_gnt     = 1'b0;
    bus.dc_rvalid  = 1'b0;
    bus.dc_rdata   = '0;
    bus.dc_done    = 1'b0;
    bus.dc_wready  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wvalid = 1'b0;
    bus.mem_wdata  = '0;

    unique case (state_q)
      S_CMD: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = we_q;
        bus.mem_addr = addr_q;
        bus.dc_gnt   = first_cmd_q && (owner_q == OWN_D);
        bus.ic_gnt   = first_cmd_q && (owner_q == OWN_I);
      end
      S_WRITE: begin
        // Only a D owner can reach WRITE, since I transactions force we=0.
        bus.mem_wvalid = 1'b1;
        bus.mem_wdata  = bus.dc_wdata;
        bus.dc_wready  = bus.mem_ready;
      end
      S_READ: begin
        if (owner_q == OWN_D) begin
          bus.dc_rvalid = bus.mem_rvalid;
          bus.dc_rdata  = bus.mem_rvalid ? bus.mem_rdata : '0;
        end else begin
          bus.ic_rvalid = bus.mem_rvalid;
          bus.ic_rdata  = bus.mem_rvalid ? bus.mem_rdata : '0;
        end
      end
      S_DONE: begin
        bus.dc_done = (owner_q == OWN_D);
        bus.ic_done = (owner_q == OWN_I);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed, self-checking bench for mem_port_arbiter (BURST_LEN=4,
// MAX_STREAK=4). Inputs change and outputs are sampled around the falling
// clock edge; the DUT updates on the rising edge. Expected grant order in the
// arbitration scenario follows the MEM_ARB_FAIRNESS_EN build option.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BURST_LEN  = 4;
  localparam int MAX_STREAK = 4;
  localparam int OUT_W      = 10 + 3 * DATA_W + ADDR_W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Every DUT output, packed, for all-zero comparisons.
  function automatic logic [OUT_W-1:0] all_outs();
    return {bus.ic_gnt, bus.ic_rvalid, bus.ic_rdata, bus.ic_done,
            bus.dc_gnt, bus.dc_rvalid, bus.dc_rdata, bus.dc_done, bus.dc_wready,
            bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wvalid, bus.mem_wdata};
  endfunction

  function automatic logic [DATA_W+4:0] ic_outs();
    return {1'b0, bus.ic_gnt, bus.ic_rvalid, bus.ic_rdata, bus.ic_done};
  endfunction

  function automatic logic [DATA_W+4:0] dc_outs();
    return {bus.dc_gnt, bus.dc_rvalid, bus.dc_rdata, bus.dc_done, bus.dc_wready};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ic_req     = 1'b0;
    bus.ic_addr    = '0;
    bus.dc_req     = 1'b0;
    bus.dc_we      = 1'b0;
    bus.dc_addr    = '0;
    bus.dc_wdata   = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Starting in the first CMD cycle of a read (gnt already checked): accept
  // the command, deliver BURST_LEN zero-wait beats base..base+3, then expect
  // done exactly one cycle after the last beat. Ends in the following IDLE
  // cycle.
  task automatic finish_read(input bit is_d, input logic [DATA_W-1:0] base,
                             input string tag);
    logic [DATA_W+1:0] got, exp;
    logic [DATA_W+4:0] other;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_cmd_req: got %b expected 1", tag, bus.mem_req);
    end
    for (int k = 0; k < BURST_LEN; k++) begin
      tick();
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + DATA_W'(k);
      #1;
      got   = is_d ? {bus.dc_rvalid, bus.dc_rdata, bus.dc_done}
                   : {bus.ic_rvalid, bus.ic_rdata, bus.ic_done};
      exp   = {1'b1, base + DATA_W'(k), 1'b0};
      other = is_d ? ic_outs() : dc_outs();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_beat%0d: got %h expected %h", tag, k, got, exp);
      end
      checks++;
      if (other !== '0) begin
        errors++;
        $display("FAIL %s_nonowner%0d: got %h expected 0", tag, k, other);
      end
    end
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #1;
    got = is_d ? {bus.dc_done, bus.ic_done, bus.mem_req, {DATA_W-1{1'b0}}}
               : {bus.ic_done, bus.dc_done, bus.mem_req, {DATA_W-1{1'b0}}};
    exp = {1'b1, 1'b0, 1'b0, {DATA_W-1{1'b0}}};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_done: got %h expected %h", tag, got, exp);
    end
    tick();
    #1;
    checks++;
    if ({bus.ic_done, bus.dc_done} !== 2'b00) begin
      errors++;
      $display("FAIL %s_done_pulse: got %b expected 00", tag, {bus.ic_done, bus.dc_done});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", all_outs());
    end
  endtask

  // Single I read with spurious mem_rvalid in IDLE and CMD.
  task automatic test_single_read();
    tick();
    bus.ic_req     = 1'b1;
    bus.ic_addr    = 32'h0000_1000;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hEE;
    #1;
    checks++;
    if ({bus.ic_gnt, bus.ic_rvalid, bus.ic_rdata} !== '0) begin
      errors++;
      $display("FAIL spurious_idle: got %b %b %h expected 0 0 0",
               bus.ic_gnt, bus.ic_rvalid, bus.ic_rdata);
    end
    tick();
    #1;
    checks++;
    if ({bus.ic_gnt, bus.dc_gnt, bus.mem_we, bus.mem_addr} !== {3'b100, 32'h0000_1000}) begin
      errors++;
      $display("FAIL single_gnt: got gnt=%b/%b we=%b addr=%h expected 1/0 0 00001000",
               bus.ic_gnt, bus.dc_gnt, bus.mem_we, bus.mem_addr);
    end
    checks++;
    if ({bus.ic_rvalid, bus.ic_rdata} !== '0) begin
      errors++;
      $display("FAIL spurious_cmd: got %b %h expected 0 0", bus.ic_rvalid, bus.ic_rdata);
    end
    bus.ic_req = 1'b0;
    finish_read(1'b0, 32'hA0, "single");
  endtask

  // D writeback with mem_ready stalls in CMD and WRITE.
  task automatic test_writeback();
    bit                pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [DATA_W-1:0] sent[$];
    int                idx    = 0;
    int                pulses = 0;
    tick();
    bus.dc_req    = 1'b1;
    bus.dc_we     = 1'b1;
    bus.dc_addr   = 32'h0000_2000;
    bus.dc_wdata  = 32'h10;
    bus.mem_ready = 1'b0;
    tick();
    #1;
    checks++;
    if ({bus.dc_gnt, bus.ic_gnt, bus.mem_req, bus.mem_we, bus.mem_addr}
        !== {4'b1011, 32'h0000_2000}) begin
      errors++;
      $display("FAIL wb_gnt: got gnt=%b/%b req=%b we=%b addr=%h expected 1/0 1 1 00002000",
               bus.dc_gnt, bus.ic_gnt, bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.dc_req = 1'b0;
    tick();
    #1;
    checks++;
    if ({bus.dc_gnt, bus.mem_req, bus.mem_we, bus.mem_addr} !== {3'b011, 32'h0000_2000}) begin
      errors++;
      $display("FAIL wb_cmd_stall: got gnt=%b req=%b we=%b addr=%h expected 0 1 1 00002000",
               bus.dc_gnt, bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.mem_ready = pat[k];
      bus.dc_wdata  = 32'h10 + DATA_W'(idx);
      #1;
      checks++;
      if ({bus.mem_wvalid, bus.dc_wready, bus.dc_done} !== {1'b1, pat[k], 1'b0}) begin
        errors++;
        $display("FAIL wb_cycle%0d: got wvalid=%b wready=%b done=%b expected 1 %b 0",
                 k, bus.mem_wvalid, bus.dc_wready, bus.dc_done, pat[k]);
      end
      if (bus.mem_wvalid && bus.mem_ready) sent.push_back(bus.mem_wdata);
      if (bus.dc_wready) pulses++;
      if (pat[k]) idx++;
    end
    tick();
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if ({bus.dc_done, bus.mem_wvalid, bus.dc_wready, bus.mem_req} !== 4'b1000) begin
      errors++;
      $display("FAIL wb_done: got done=%b wvalid=%b wready=%b req=%b expected 1 0 0 0",
               bus.dc_done, bus.mem_wvalid, bus.dc_wready, bus.mem_req);
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL wb_wready_pulses: got %0d expected 4", pulses);
    end
    checks++;
    if (sent.size() !== 4) begin
      errors++;
      $display("FAIL wb_beat_count: got %0d expected 4", sent.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (sent[k] !== 32'h10 + DATA_W'(k)) begin
          errors++;
          $display("FAIL wb_beat%0d: got %h expected %h", k, sent[k], 32'h10 + k);
        end
      end
    end
    tick();
    #1;
    checks++;
    if (bus.dc_done !== 1'b0) begin
      errors++;
      $display("FAIL wb_done_pulse: got %b expected 0", bus.dc_done);
    end
  endtask

  // Both requests in one IDLE cycle: D first, then I with its own address.
  task automatic test_both_req();
    tick();
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_3000;
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h0000_4000;
    tick();
    #1;
    checks++;
    if ({bus.dc_gnt, bus.ic_gnt, bus.mem_addr} !== {2'b10, 32'h0000_4000}) begin
      errors++;
      $display("FAIL both_d_first: got gnt=%b/%b addr=%h expected 1/0 00004000",
               bus.dc_gnt, bus.ic_gnt, bus.mem_addr);
    end
    bus.dc_req = 1'b0;
    finish_read(1'b1, 32'hB0, "both_d");
    tick();
    #1;
    checks++;
    if ({bus.ic_gnt, bus.dc_gnt, bus.mem_we, bus.mem_addr} !== {3'b100, 32'h0000_3000}) begin
      errors++;
      $display("FAIL both_i_second: got gnt=%b/%b we=%b addr=%h expected 1/0 0 00003000",
               bus.ic_gnt, bus.dc_gnt, bus.mem_we, bus.mem_addr);
    end
    bus.ic_req = 1'b0;
    finish_read(1'b0, 32'hC0, "both_i");
  endtask

  // Both requests held continuously through six grants.
  task automatic test_fairness();
    bit got_gnt;
    bit is_d;
    bit exp_d;
    tick();
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_5000;
    bus.dc_req  = 1'b1;
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h0000_6000;
    for (int g = 0; g < 6; g++) begin
      got_gnt = 1'b0;
      for (int w = 0; w < 4 && !got_gnt; w++) begin
        tick();
        #1;
        if (bus.ic_gnt || bus.dc_gnt) got_gnt = 1'b1;
      end
      checks++;
      if (!got_gnt) begin
        errors++;
        $display("FAIL fair_grant%0d_timeout: no gnt within 4 cycles", g);
        break;
      end
`ifdef MEM_ARB_FAIRNESS_EN
      exp_d = (g != MAX_STREAK);
`else
      exp_d = 1'b1;
`endif
      is_d = bus.dc_gnt;
      checks++;
      if ({bus.dc_gnt, bus.ic_gnt} !== {exp_d, !exp_d}) begin
        errors++;
        $display("FAIL fair_grant%0d: got dc/ic gnt %b/%b expected %b/%b",
                 g, bus.dc_gnt, bus.ic_gnt, exp_d, !exp_d);
      end
      finish_read(is_d, 32'hD0 + DATA_W'(g * 16), $sformatf("fair%0d", g));
    end
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
  endtask

  // Reset in the third READ beat, then a clean transaction.
  task automatic test_reset_mid_read();
    tick();
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_7000;
    tick();
    #1;
    checks++;
    if (bus.ic_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rmr_gnt: got %b expected 1", bus.ic_gnt);
    end
    bus.ic_req    = 1'b0;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h51 + DATA_W'(k);
    end
    tick();
    bus.mem_rdata = 32'h53;
    #1;
    checks++;
    if ({bus.ic_rvalid, bus.ic_rdata} !== {1'b1, 32'h53}) begin
      errors++;
      $display("FAIL rmr_beat3: got %b %h expected 1 00000053", bus.ic_rvalid, bus.ic_rdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL rmr_async_clear: got %h expected 0", all_outs());
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_7100;
    tick();
    #1;
    checks++;
    if ({bus.ic_gnt, bus.mem_req, bus.mem_addr} !== {2'b11, 32'h0000_7100}) begin
      errors++;
      $display("FAIL rmr_regrant: got gnt=%b req=%b addr=%h expected 1 1 00007100",
               bus.ic_gnt, bus.mem_req, bus.mem_addr);
    end
    bus.ic_req = 1'b0;
    finish_read(1'b0, 32'h60, "rmr_clean");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_writeback();
    test_both_req();
    test_fairness();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the I-cache refill engine and the D-cache refill/writeback engine. It arbitrates one line-sized burst transaction at a time and sequences the command, write-data and read-data phases. It routes returned data and completion back to the owning cache. It sits between both caches and the memory interface, beside the hazard controller; cache miss stalls last until this block signals done.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, beat width
- BURST_LEN, 4, beats per line transaction (≥1)
- MAX_STREAK, 4, consecutive D grants allowed while I waits (fairness build only, ≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ic_req  in  1  I-cache read request, level, held until ic_gnt seen
- ic_addr  in  ADDR_W  line address, valid while ic_req
- ic_gnt  out  1  one-cycle pulse: I request accepted
- ic_rvalid  out  1  read beat valid to I-cache
- ic_rdata  out  DATA_W  read beat
- ic_done  out  1  one-cycle pulse: I transaction complete
- dc_req  in  1  D-cache request, level, held until dc_gnt seen
- dc_we  in  1  1 = writeback, 0 = refill; valid while dc_req
- dc_addr  in  ADDR_W  line address
- dc_wdata  in  DATA_W  current write beat
- dc_wready  out  1  current write beat consumed; D-cache advances beat
- dc_gnt, dc_rvalid, dc_rdata, dc_done  out  1/1/DATA_W/1  as I-side
- mem_req  out  1  command valid
- mem_we  out  1  command is write
- mem_addr  out  ADDR_W  command address
- mem_wvalid  out  1  write beat valid
- mem_wdata  out  DATA_W  write beat
- mem_ready  in  1  accepts command (CMD) or write beat (WRITE)
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  DATA_W  read beat

## Operation
- States: IDLE, CMD, WRITE, READ, DONE. Registers: owner (I/D), addr, we, beat counter (clog2(BURST_LEN+1) bits), streak counter.
- IDLE: samples requests. Neither request: stay. One request: grant it. Both: grant D, except in the fairness case (see Configuration). On grant, capture owner, addr, and we (we forced 0 for I), then go to CMD.
- CMD: mem_req=1, mem_addr/mem_we from the captured registers. The owner's gnt is high only in the first CMD cycle. On mem_ready: go to WRITE if we, else READ. Beat counter clears.
- WRITE: mem_wvalid=1 and mem_wdata=dc_wdata. dc_wready=mem_ready. Each mem_ready increments the counter. The beat that brings the count to BURST_LEN moves to DONE.
- READ: the owner's rvalid/rdata follow mem_rvalid/mem_rdata combinationally; the non-owner's rvalid=0. Each mem_rvalid increments the counter; the last beat moves to DONE. mem_rvalid outside READ is ignored.
- DONE: the owner's done=1 for one cycle, then IDLE. Requesters may raise req again from the DONE cycle onward.
- Requests arriving while busy wait; they are sampled only in IDLE. Deasserting req after gnt has no effect on the transaction in flight.
- rdata outputs are 0 when the matching rvalid is 0.

## Timing
- Reset (asynchronous): state IDLE, all counters 0, every output 0. A transaction in flight is abandoned; mem_req drops in the same cycle.
- Request seen in IDLE at cycle t: gnt and mem_req at t+1.
- Zero-wait memory (mem_ready=1; read beats start the cycle after command accept): read done at t+2+BURST_LEN. Next grant at t+4+BURST_LEN earliest. Writes have the same timing.
- mem_ready stalls extend CMD/WRITE with outputs held stable. Gaps in mem_rvalid extend READ.
- Owner data/done outputs are never asserted to the non-owner.

## Configuration
- MEM_ARB_FAIRNESS_EN defined:
  - The streak counter tracks consecutive D grants made while ic_req=1.
  - It clears on any I grant, or on a D grant with ic_req=0.
  - When streak==MAX_STREAK and both requests are pending, I is granted.
- Undefined: strict D-over-I priority. The streak counter is not built.

## Test plan
- Single I read, BURST_LEN=4, zero-wait, rdata 0xA0..0xA3:
  - ic_gnt at t+1.
  - ic_rvalid for 4 cycles carrying 0xA0..0xA3.
  - ic_done at t+6.
  - dc_* outputs stay 0.
- D writeback, dc_wdata 0x10..0x13, mem_ready toggling 1,0,1,1,0,1:
  - Exactly 4 beats leave in order 0x10..0x13.
  - dc_wready pulses 4 times.
  - dc_done follows the last beat.
- Both req in the same IDLE cycle:
  - dc_gnt fires first.
  - ic_gnt fires after dc_done.
  - Captured ic_addr unchanged.
- Fairness build, MAX_STREAK=4, dc_req and ic_req held continuously:
  - Grant order D,D,D,D,I,D,…
  - Non-fairness build: I never granted while dc_req held.
- rst asserted mid-READ after 2 beats:
  - Same cycle: all outputs 0, mem_req 0.
  - After release, a new ic_req is granted at t+1 with a clean beat count (4 beats to done).
- Spurious mem_rvalid during CMD and IDLE: no rvalid forwarded, beat count unaffected.
